// File: rtl/ofm_writer.sv
// ofm_writer: output-feature-map write-back with multi-group read-modify-write accumulation
//
// Accepts one partial-sum pixel per valid/ready handshake and writes it to the
// output buffer in raster order (column fastest, then row, then channel, with the
// input-channel group outermost). Group 0 writes the value directly; every later
// group reads the stored value back, adds the new partial sum with saturation and
// writes the result.
//
// Optional feature: define RELU_EN to clip negative results to 0 on the last group.
//
// Ports:
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset
//   i_start     one-cycle pulse starting a full layer write-back
//   i_in_valid  i_in_data holds a valid partial sum
//   i_in_data   signed partial sum for the current pixel
//   o_in_ready  writer accepts i_in_data this cycle
//   o_out_addr  output buffer address
//   o_out_din   output buffer write data
//   i_out_dout  output buffer read data (1-cycle read latency)
//   o_out_ena   output buffer port enable
//   o_out_wea   output buffer byte write enables (all ones or all zeros)
//   o_busy      layer write-back in progress
//   o_done      one-cycle pulse after the last write of the layer
module ofm_writer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int OUT_SIZE    = 28,
    parameter int OUT_CHANNEL = 6,
    parameter int N_GROUPS    = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [DATA_W-1:0]     i_in_data,
    output logic                  o_in_ready,
    output logic [ADDR_W-1:0]     o_out_addr,
    output logic [DATA_W-1:0]     o_out_din,
    input  logic [DATA_W-1:0]     i_out_dout,
    output logic                  o_out_ena,
    output logic [DATA_W/8-1:0]   o_out_wea,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int CW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1;
    localparam int MW = OUT_CHANNEL > 1 ? $clog2(OUT_CHANNEL) : 1;
    localparam int GW = N_GROUPS > 1 ? $clog2(N_GROUPS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       r_row;
    logic [MW-1:0]       r_ch;
    logic [GW-1:0]       r_grp;
    logic [DATA_W-1:0]   r_cap;
    logic                r_in_ready;
    logic                r_ena;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_sat;
    logic [DATA_W-1:0]   w_acc_wr;
    logic [DATA_W-1:0]   w_cap_wr;
    logic                w_c_end;
    logic                w_r_end;
    logic                w_m_end;
    logic                w_last_grp;
    logic                w_last_pix;

    // Address is formed in 32-bit arithmetic and then truncated to ADDR_W.
    assign w_addr = ADDR_W'(32'(r_ch) * 32'(OUT_SIZE * OUT_SIZE) + 32'(r_row) * 32'(OUT_SIZE) + 32'(r_col));

    // One extra bit catches overflow; differing top bits mean the sum left the DATA_W range.
    assign w_sum = {i_out_dout[DATA_W-1], i_out_dout} + {r_cap[DATA_W-1], r_cap};
    assign w_sat = (w_sum[DATA_W] != w_sum[DATA_W-1])
                 ? (w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                 : w_sum[DATA_W-1:0];

    assign w_c_end    = r_col == CW'(OUT_SIZE - 1);
    assign w_r_end    = r_row == CW'(OUT_SIZE - 1);
    assign w_m_end    = r_ch == MW'(OUT_CHANNEL - 1);
    assign w_last_grp = r_grp == GW'(N_GROUPS - 1);
    assign w_last_pix = w_c_end && w_r_end && w_m_end && w_last_grp;

`ifdef RELU_EN
    // Only the final group is clipped; earlier groups must keep their sign to accumulate.
    assign w_acc_wr = (w_last_grp && w_sat[DATA_W-1]) ? '0 : w_sat;
    assign w_cap_wr = (w_last_grp && i_in_data[DATA_W-1]) ? '0 : i_in_data;
`else
    assign w_acc_wr = w_sat;
    assign w_cap_wr = i_in_data;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_ch       <= '0;
            r_grp      <= '0;
            r_cap      <= '0;
            r_in_ready <= 1'b0;
            r_ena      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= S_ACCEPT;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (i_in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_cap      <= i_in_data;
                        r_ena      <= 1'b1;
                        r_addr     <= w_addr;
                        r_we       <= r_grp == '0;
                        r_din      <= w_cap_wr;
                        r_state    <= r_grp == '0 ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    r_ena   <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data issued in READ is valid now; register the accumulated result.
                    r_ena   <= 1'b1;
                    r_we    <= 1'b1;
                    r_din   <= w_acc_wr;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_ena <= 1'b0;
                    r_we  <= 1'b0;
                    r_col <= w_c_end ? '0 : r_col + 1'b1;
                    if (w_c_end)
                        r_row <= w_r_end ? '0 : r_row + 1'b1;
                    if (w_c_end && w_r_end)
                        r_ch <= w_m_end ? '0 : r_ch + 1'b1;
                    if (w_c_end && w_r_end && w_m_end)
                        r_grp <= w_last_grp ? '0 : r_grp + 1'b1;
                    if (w_last_pix) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= S_ACCEPT;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_out_addr = r_addr;
    assign o_out_din  = r_din;
    assign o_out_ena  = r_ena;
    assign o_out_wea  = {(DATA_W/8){r_we}};
    assign o_busy     = r_busy;
    assign o_done     = r_done;
endmodule

// File: tb/tb_ofm_writer.sv
// tb_ofm_writer: randomized self-checking bench for ofm_writer with a 1-cycle-latency buffer model
module tb_ofm_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        o_in_ready;
    logic [15:0] o_out_addr;
    logic [15:0] o_out_din;
    logic [15:0] dout;
    logic        o_out_ena;
    logic [1:0]  o_out_wea;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    ofm_writer #(.DATA_W(16), .ADDR_W(16), .OUT_SIZE(2), .OUT_CHANNEL(2), .N_GROUPS(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(o_in_ready), .o_out_addr(o_out_addr), .o_out_din(o_out_din), .i_out_dout(dout),
        .o_out_ena(o_out_ena), .o_out_wea(o_out_wea), .o_busy(o_busy), .o_done(o_done)
    );

    logic [15:0] mem [0:63];
    int          cyc = 0;
    int          wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    int          rc[$];
    int          hs[$];
    int          n_done = 0;
    int          n_done_busy = 0;
    int          checks = 0;
    int          errors = 0;
    int          b_w, b_r, b_h, b_d, b_db;

    // Buffer model plus event log of writes, reads, handshakes and done pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_out_ena) begin
            if (o_out_wea == 2'b11) begin
                mem[o_out_addr[5:0]] <= o_out_din;
                wa.push_back(int'(o_out_addr));
                wd.push_back(o_out_din);
                wc.push_back(cyc);
            end else begin
                dout <= mem[o_out_addr[5:0]];
                rc.push_back(cyc);
            end
        end
        if (in_valid && o_in_ready) hs.push_back(cyc);
        if (o_done) n_done <= n_done + 1;
        if (o_done && o_busy) n_done_busy <= n_done_busy + 1;
    end

    function automatic logic [15:0] exp_final(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_w = wa.size(); b_r = rc.size(); b_h = hs.size(); b_d = n_done; b_db = n_done_busy;
    endtask

    task automatic feed(input logic [15:0] v, input int gap, inout bit ok);
        bit got;
        got = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_valid = 1'b1;
        in_data = v;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = o_in_ready;
            tick();
        end
        if (!got) ok = 1'b0;
    endtask

    task automatic wait_done(inout bit ok);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = o_done;
            tick();
        end
        if (!seen) ok = 1'b0;
    endtask

    task automatic run_layer(input logic [15:0] g0 [8], input logic [15:0] g1 [8], input int maxgap, output bit ok);
        ok = 1'b1;
        mark();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) feed(g0[i], int'($urandom_range(maxgap, 0)), ok);
        for (int i = 0; i < 8; i++) feed(g1[i], int'($urandom_range(maxgap, 0)), ok);
        in_valid = 1'b0;
        wait_done(ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({o_in_ready, o_out_ena, o_out_wea, o_busy, o_done, o_out_addr, o_out_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b ena=%b wea=%b busy=%b done=%b addr=%h din=%h want all 0",
                     o_in_ready, o_out_ena, o_out_wea, o_busy, o_done, o_out_addr, o_out_din);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h1234;
        mark();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({o_in_ready, o_out_ena, o_out_wea, o_busy, o_done, o_out_addr, o_out_din} !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got ready=%b ena=%b busy=%b done=%b want all 0",
                         i, o_in_ready, o_out_ena, o_busy, o_done);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (hs.size() != b_h || wa.size() != b_w || rc.size() != b_r) begin
            errors++;
            $display("FAIL idle_activity got hs=%0d wr=%0d rd=%0d want 0 0 0", hs.size() - b_h, wa.size() - b_w, rc.size() - b_r);
        end
    endtask

    task automatic test_basic();
        logic [15:0] g0 [8];
        logic [15:0] g1 [8];
        bit ok;
        for (int i = 0; i < 8; i++) begin g0[i] = 16'(i + 1); g1[i] = 16'd10; end
        run_layer(g0, g1, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout got ok=0 want 1"); end
        checks++;
        if (wa.size() - b_w != 16 || rc.size() - b_r != 8 || hs.size() - b_h != 16) begin
            errors++;
            $display("FAIL basic_counts got wr=%0d rd=%0d hs=%0d want 16 8 16", wa.size() - b_w, rc.size() - b_r, hs.size() - b_h);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wa[b_w + i] != i % 8 || wd[b_w + i] !== (i < 8 ? g0[i] : exp_final(g0[i - 8], g1[i - 8]))) begin
                    errors++;
                    $display("FAIL basic_write %0d got addr=%0d data=%h want addr=%0d", i, wa[b_w + i], wd[b_w + i], i % 8);
                end
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (hs[b_h + i] - hs[b_h + i - 1] != 2) begin
                    errors++;
                    $display("FAIL basic_ready_spacing %0d got %0d want 2", i, hs[b_h + i] - hs[b_h + i - 1]);
                end
            end
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (wc[b_w + 8 + j] - rc[b_r + j] != 2) begin
                    errors++;
                    $display("FAIL basic_read_to_write %0d got %0d want 2", j, wc[b_w + 8 + j] - rc[b_r + j]);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== 16'(11 + i)) begin
                errors++;
                $display("FAIL basic_final addr %0d got %h want %h", i, mem[i], 16'(11 + i));
            end
        end
        checks++;
        if (n_done - b_d != 1 || n_done_busy != b_db || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got pulses=%0d done_with_busy=%0d busy=%b want 1 0 0", n_done - b_d, n_done_busy - b_db, o_busy);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] g0 [8];
        logic [15:0] g1 [8];
        logic [15:0] want1;
        bit ok;
        for (int i = 0; i < 8; i++) begin g0[i] = 16'($urandom); g1[i] = 16'($urandom); end
        g0[0] = 16'h7FF0; g1[0] = 16'h0100;
        g0[1] = 16'h8000; g1[1] = 16'hFFFF;
`ifdef RELU_EN
        want1 = 16'h0000;
`else
        want1 = 16'h8000;
`endif
        run_layer(g0, g1, 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_timeout got ok=0 want 1"); end
        checks++;
        if (mem[0] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %h want 7fff", mem[0]); end
        checks++;
        if (mem[1] !== want1) begin errors++; $display("FAIL sat_neg got %h want %h", mem[1], want1); end
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (mem[i] !== exp_final(g0[i], g1[i])) begin
                errors++;
                $display("FAIL sat_other addr %0d got %h want %h", i, mem[i], exp_final(g0[i], g1[i]));
            end
        end
    endtask

    task automatic test_relu();
        logic [15:0] g0 [8];
        logic [15:0] g1 [8];
        logic [15:0] want;
        bit ok;
        for (int i = 0; i < 8; i++) begin g0[i] = 16'($urandom_range(2000, 0)); g1[i] = 16'($urandom_range(2000, 0)); end
        g0[0] = 16'hFFFB; g1[0] = 16'hFFFD;
`ifdef RELU_EN
        want = 16'h0000;
`else
        want = 16'hFFF8;
`endif
        run_layer(g0, g1, 1, ok);
        checks++;
        if (!ok || wa.size() - b_w != 16) begin
            errors++;
            $display("FAIL relu_run got ok=%0d writes=%0d want 1 16", ok, wa.size() - b_w);
        end else begin
            checks++;
            if (wd[b_w] !== 16'hFFFB) begin errors++; $display("FAIL relu_group0 got %h want fffb", wd[b_w]); end
        end
        checks++;
        if (mem[0] !== want) begin errors++; $display("FAIL relu_final got %h want %h", mem[0], want); end
        checks++;
        if (mem[5] !== exp_final(g0[5], g1[5])) begin errors++; $display("FAIL relu_positive got %h want %h", mem[5], exp_final(g0[5], g1[5])); end
    endtask

    task automatic test_random();
        logic [15:0] g0 [8];
        logic [15:0] g1 [8];
        bit ok;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) begin g0[i] = 16'($urandom); g1[i] = 16'($urandom); end
            run_layer(g0, g1, 3, ok);
            checks++;
            if (!ok || wa.size() - b_w != 16 || rc.size() - b_r != 8) begin
                errors++;
                $display("FAIL rand_counts run %0d got ok=%0d wr=%0d rd=%0d want 1 16 8", n, ok, wa.size() - b_w, rc.size() - b_r);
            end else begin
                for (int i = 0; i < 16; i++) begin
                    checks++;
                    if (wa[b_w + i] != i % 8 || wd[b_w + i] !== (i < 8 ? g0[i] : exp_final(g0[i - 8], g1[i - 8]))) begin
                        errors++;
                        $display("FAIL rand_write run %0d idx %0d got addr=%0d data=%h want addr=%0d data=%h", n, i,
                                 wa[b_w + i], wd[b_w + i], i % 8, (i < 8 ? g0[i] : exp_final(g0[i - 8], g1[i - 8])));
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure_reset();
        int nw, nh;
        bit ok;
        ok = 1'b1;
        mark();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) feed(16'($urandom), 0, ok);
        in_valid = 1'b0;
        tick();
        nw = wa.size();
        nh = hs.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({o_out_ena, o_in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ena=%b ready=%b want 0 1", i, o_out_ena, o_in_ready);
            end
            tick();
        end
        checks++;
        if (wa.size() != nw || hs.size() != nh || nw - b_w != 3) begin
            errors++;
            $display("FAIL bp_activity got writes=%0d hs_delta=%0d want 3 0", wa.size() - b_w, hs.size() - nh);
        end
        for (int i = 3; i < 8; i++) feed(16'($urandom), 0, ok);
        feed(16'($urandom), 0, ok);
        in_valid = 1'b0;
        tick();
        checks++;
        if (!ok || wa.size() - b_w != 8 || rc.size() - b_r != 1 || o_out_ena !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait_state got ok=%0d wr=%0d rd=%0d ena=%b want 1 8 1 0", ok, wa.size() - b_w, rc.size() - b_r, o_out_ena);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa[b_w + i] != i) begin errors++; $display("FAIL bp_addr %0d got %0d want %0d", i, wa[b_w + i], i); end
            end
        end
        rst = 1'b1;
        nw = wa.size();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_in_ready, o_out_ena, o_out_wea, o_busy, o_done, o_out_addr, o_out_din} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b ena=%b wea=%b busy=%b done=%b addr=%h want all 0",
                     o_in_ready, o_out_ena, o_out_wea, o_busy, o_done, o_out_addr);
        end
        tick();
        repeat (2) tick();
        checks++;
        if (wa.size() != nw) begin errors++; $display("FAIL midreset_write got %0d writes want 0", wa.size() - nw); end
    endtask

    task automatic test_restart();
        logic [15:0] g0 [8];
        logic [15:0] g1 [8];
        bit ok;
        for (int i = 0; i < 8; i++) begin g0[i] = 16'($urandom); g1[i] = 16'($urandom); end
        run_layer(g0, g1, 1, ok);
        checks++;
        if (!ok || wa.size() - b_w != 16 || rc.size() - b_r != 8) begin
            errors++;
            $display("FAIL restart_counts got ok=%0d wr=%0d rd=%0d want 1 16 8", ok, wa.size() - b_w, rc.size() - b_r);
        end else begin
            checks++;
            if (wa[b_w] != 0 || wd[b_w] !== g0[0] || rc[b_r] <= wc[b_w + 7]) begin
                errors++;
                $display("FAIL restart_first got addr=%0d data=%h want addr=0 data=%h with no read before group 1",
                         wa[b_w], wd[b_w], g0[0]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== exp_final(g0[i], g1[i])) begin
                errors++;
                $display("FAIL restart_final addr %0d got %h want %h", i, mem[i], exp_final(g0[i], g1[i]));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_random();
        test_backpressure_reset();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
